// File: rtl/ws2812_tx.sv
// ws2812_tx: pops GRB pixels from a FWFT FIFO and drives them onto a WS2812 data line, then latches.
module ws2812_tx #(
  parameter int PIXEL_WIDTH  = 24,
  parameter int LED_COUNT    = 64,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 63,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_empty,
  input  logic [PIXEL_WIDTH-1:0] i_data,
  output logic                   o_rd,
  output logic                   o_dout,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_underrun
);
  localparam int CMAX = BIT_CYCLES > RESET_CYCLES ? BIT_CYCLES : RESET_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = $clog2(PIXEL_WIDTH);
  localparam int PW   = LED_COUNT > 1 ? $clog2(LED_COUNT) : 1;
  typedef enum logic [1:0] {S_IDLE, S_BIT, S_WAIT, S_LATCH} state_t;
  state_t                 r_state;
  logic [CW-1:0]          r_cyc;
  logic [BW-1:0]          r_bit;
  logic [PW-1:0]          r_pix;
  logic [PIXEL_WIDTH-1:0] r_shift;
  logic                   r_dout;
  logic                   r_done;
  logic                   r_underrun;
  logic                   w_bit_end;
  logic                   w_last_pix;
  logic                   w_load;
  logic [CW-1:0]          w_cyc_nxt;
  logic [CW-1:0]          w_thx;
  assign w_bit_end  = r_state == S_BIT && r_cyc == CW'(BIT_CYCLES - 1);
  assign w_last_pix = r_pix == PW'(LED_COUNT - 1);
  // the pop is gated by reset so a held reset never drains the FIFO
  assign w_load     = !i_empty && !i_reset &&
                      (r_state == S_IDLE || r_state == S_WAIT || (w_bit_end && r_bit == '0 && !w_last_pix));
  assign w_cyc_nxt  = r_cyc + 1'b1;
  assign w_thx      = r_shift[PIXEL_WIDTH-1] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
  assign o_rd         = w_load;
  assign o_dout       = r_dout;
  assign o_busy       = r_state != S_IDLE;
  assign o_frame_done = r_done;
  assign o_underrun   = r_underrun;
  // r_dout is computed from the next cycle's position so the pin is a bare flop
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_bit      <= '0;
      r_pix      <= '0;
      r_shift    <= '0;
      r_dout     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_state <= S_BIT;
        r_shift <= i_data;
        r_bit   <= BW'(PIXEL_WIDTH - 1);
        r_cyc   <= '0;
        r_dout  <= 1'b1;
        if (r_state == S_BIT) r_pix <= r_pix + 1'b1;
      end else begin
        case (r_state)
          S_BIT: begin
            if (!w_bit_end) begin
              r_cyc  <= w_cyc_nxt;
              r_dout <= w_cyc_nxt < w_thx;
            end else if (r_bit != '0) begin
              r_shift <= r_shift << 1;
              r_bit   <= r_bit - 1'b1;
              r_cyc   <= '0;
              r_dout  <= 1'b1;
            end else begin
              r_cyc   <= '0;
              r_dout  <= 1'b0;
              r_state <= w_last_pix ? S_LATCH : S_WAIT;
              r_pix   <= w_last_pix ? r_pix : r_pix + 1'b1;
            end
          end
          S_WAIT: begin
            if (r_cyc == CW'(RESET_CYCLES - 1)) begin
              r_underrun <= 1'b1;
              r_pix      <= '0;
              r_cyc      <= '0;
              r_state    <= S_IDLE;
            end else r_cyc <= w_cyc_nxt;
          end
          S_LATCH: begin
            if (r_cyc == CW'(RESET_CYCLES - 1)) begin
              r_done  <= 1'b1;
              r_pix   <= '0;
              r_cyc   <= '0;
              r_state <= S_IDLE;
            end else r_cyc <= w_cyc_nxt;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: drives ws2812_tx from a queue FIFO and checks every cycle against a waveform-level model.
module tb_ws2812_tx;
  localparam int PW = 24, LC = 2, T0 = 2, T1 = 4, BC = 6, RC = 10;
  logic          clk = 1'b0, rst = 1'b1, empty = 1'b1;
  logic [PW-1:0] data = '0;
  logic          rd, dout, busy, done, und;
  always #5 clk = ~clk;
  ws2812_tx #(.PIXEL_WIDTH(PW), .LED_COUNT(LC), .T0H_CYCLES(T0), .T1H_CYCLES(T1),
              .BIT_CYCLES(BC), .RESET_CYCLES(RC)) dut (
    .i_clk(clk), .i_reset(rst), .i_empty(empty), .i_data(data), .o_rd(rd),
    .o_dout(dout), .o_busy(busy), .o_frame_done(done), .o_underrun(und));
  typedef enum {M_IDLE, M_SEND, M_WAIT, M_LATCH} mmode_t;
  int            checks = 0, errors = 0;
  logic [PW-1:0] fifo[$];
  mmode_t        mode;
  bit            wave[$];
  int            loaded, cnt;
  bit            m_done, m_und;
  int            cyc = 0, nrd, ndone, nhigh, nbusy, tdone, tund, tfall;
  int            rises[$], rdt[$];
  bit            prev_dout = 0, prev_und = 0, prev_busy = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  function automatic void model_reset();
    mode = M_IDLE; wave.delete(); loaded = 0; cnt = 0; m_done = 0; m_und = 0;
  endfunction
  function automatic void clear_obs();
    nrd = 0; ndone = 0; nhigh = 0; nbusy = 0; tdone = -1; tund = -1; tfall = -1;
    rises.delete(); rdt.delete();
  endfunction
  // pixel -> pin waveform, one entry per clock
  function automatic void load_wave(logic [PW-1:0] px);
    wave.delete();
    for (int b = PW - 1; b >= 0; b--) begin
      int th = px[b] ? T1 : T0;
      for (int c = 0; c < BC; c++) wave.push_back(c < th);
    end
  endfunction
  task automatic step();
    bit exp_rd, rd_s;
    @(negedge clk);
    empty = fifo.size() == 0;
    data  = empty ? '0 : fifo[0];
    #1;
    exp_rd = !rst && !empty &&
             (mode == M_IDLE || mode == M_WAIT || (mode == M_SEND && wave.size() == 1 && loaded < LC));
    chk("o_rd", rd, exp_rd);
    chk("o_dout", dout, (mode == M_SEND && wave.size() > 0) ? wave[0] : 0);
    chk("o_busy", busy, mode != M_IDLE);
    chk("o_frame_done", done, m_done);
    chk("o_underrun", und, m_und);
    if (dout && !prev_dout) rises.push_back(cyc);
    if (und && !prev_und && tund < 0) tund = cyc;
    if (!busy && prev_busy && tfall < 0) tfall = cyc;
    if (done) tdone = cyc;
    if (rd) rdt.push_back(cyc);
    prev_dout = dout; prev_und = und; prev_busy = busy;
    nrd += int'(rd); ndone += int'(done); nhigh += int'(dout); nbusy += int'(busy);
    rd_s = rd;
    @(posedge clk);
    cyc++;
    if (rd_s && fifo.size() > 0) void'(fifo.pop_front());
    m_done = 0;
    if (rst) model_reset();
    else if (exp_rd) begin
      load_wave(data); mode = M_SEND; loaded++;
    end else begin
      case (mode)
        M_SEND: begin
          void'(wave.pop_front());
          if (wave.size() == 0) begin mode = (loaded == LC) ? M_LATCH : M_WAIT; cnt = 0; end
        end
        M_WAIT:  begin cnt++; if (cnt == RC) begin m_und = 1; mode = M_IDLE; loaded = 0; end end
        M_LATCH: begin cnt++; if (cnt == RC) begin m_done = 1; mode = M_IDLE; loaded = 0; end end
        default: ;
      endcase
    end
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic run_to_idle(int lim);
    int i = 0;
    step();
    while (mode != M_IDLE && i < lim) begin step(); i++; end
    if (mode != M_IDLE) chk("timeout_idle", 0, 1);
  endtask
  task automatic run_to_wait(int lim);
    int i = 0;
    while (mode != M_WAIT && i < lim) begin step(); i++; end
    if (mode != M_WAIT) chk("timeout_wait", 0, 1);
  endtask
  initial begin
    int fsz, i;
    model_reset(); clear_obs();
    run(3);
    chk("reset_dout", dout, 0); chk("reset_busy", busy, 0); chk("reset_und", und, 0);
    #2 rst = 1'b0;
    // full frame, both pixels preloaded
    clear_obs();
    fifo.push_back(24'hFF0000); fifo.push_back(24'h00000F);
    run_to_idle(1000); run(3);
    chk("f1_rd_count", nrd, 2);
    chk("f1_rise_count", rises.size(), 48);
    chk("f1_high_cycles", nhigh, 120);
    chk("f1_length", tdone - rises[0], 298);
    chk("f1_seam", rises[24] - rises[23], 6);
    chk("f1_rd_last_cycle", rdt[1], rises[23] + 5);
    chk("f1_done_count", ndone, 1);
    chk("f1_und", und, 0);
    // short stall: five extra low cycles at the seam
    clear_obs();
    fifo.push_back(24'hA5C33C);
    run_to_wait(1000); run(4);
    fifo.push_back(24'h0F0F0F);
    run_to_idle(1000); run(3);
    chk("stall_seam", rises[24] - rises[23], 11);
    chk("stall_length", tdone - rises[0], 303);
    chk("stall_done", ndone, 1);
    chk("stall_und", und, 0);
    // underrun abort after one pixel
    clear_obs();
    fifo.push_back(24'h123456);
    run_to_idle(1000); run(3);
    chk("ur_flag", und, 1);
    chk("ur_no_done", ndone, 0);
    chk("ur_wait_len", tund - (rises[23] + BC), RC);
    chk("ur_busy_fall", tfall, tund);
    clear_obs();
    fifo.push_back(24'h800001);
    run_to_wait(1000);
    fifo.push_back(24'h7FFFFE);
    run_to_idle(1000); run(3);
    chk("ur_new_frame_done", ndone, 1);
    chk("ur_new_frame_rd", nrd, 2);
    chk("ur_sticky", und, 1);
    // idle with empty FIFO
    clear_obs();
    run(100);
    chk("idle_rd", nrd, 0); chk("idle_high", nhigh, 0); chk("idle_busy", nbusy, 0);
    // asynchronous reset while the line is high
    clear_obs();
    fifo.push_back(24'hFFFFFF); fifo.push_back(24'h00FF00);
    i = 0;
    while (!(mode == M_SEND && wave.size() > 0 && wave[0] && wave.size() < 120) && i < 500) begin step(); i++; end
    #2;
    chk("ar_pre_dout", dout, 1);
    fsz = fifo.size();
    rst = 1'b1;
    #1;
    chk("ar_dout", dout, 0); chk("ar_busy", busy, 0); chk("ar_rd", rd, 0); chk("ar_und", und, 0);
    model_reset();
    step();
    chk("ar_fifo_kept", fifo.size(), fsz);
    #2 rst = 1'b0;
    clear_obs();
    run(2);
    fifo.push_back(24'h3C3C3C);
    run_to_idle(1000); run(3);
    chk("ar_fresh_done", ndone, 1);
    chk("ar_fresh_rd", nrd, 2);
    // randomized pixels and gaps, some long enough to abort a frame
    for (int p = 0; p < 60; p++) begin
      if (fifo.size() < 16) fifo.push_back(24'($urandom));
      run($urandom_range(0, 180));
    end
    run_to_idle(2000);
    if (fifo.size() > 0) run_to_idle(2000);
    run(RC + 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
